// File: rtl/mem_wait_responder_pkg.sv
// rtl/mem_wait_responder_pkg.sv - shared constants and FSM encoding for the wait-state memory responder
package mem_wait_responder_pkg;

    // Bus width shared with DATAPATH/CONTROL.
    localparam int BUS_WIDTH = 32;

    // Largest legal WAIT_STATES value; sizes the wait counter.
    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = $clog2(WAIT_STATES_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_wait_ram.sv
// rtl/mem_wait_ram.sv - word RAM with synchronous write and asynchronous read
//   clk_i    : write clock
//   we_i     : write enable
//   idx_i    : word index (shared by read and write)
//   wdata_i  : write data
//   rdata_o  : read data at idx_i (combinational)
module mem_wait_ram
    import mem_wait_responder_pkg::*;
#(
    parameter int DATA_W = BUS_WIDTH,
    parameter int IDX_W  = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**IDX_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - memory-side RD/WRMAIN/ACK responder with fixed wait states
//   MEM_WAIT_RESPONDER_CLOCK_50      : clock
//   MEM_WAIT_RESPONDER_ResetInLow_In : async active-low reset
//   MEM_WAIT_RESPONDER_A_InBus       : byte address
//   MEM_WAIT_RESPONDER_B_InBus       : write data
//   MEM_WAIT_RESPONDER_RD_In         : read request (level)
//   MEM_WAIT_RESPONDER_WRMain_In     : write request (level)
//   MEM_WAIT_RESPONDER_ACK_Out       : one-cycle completion pulse
//   MEM_WAIT_RESPONDER_Data_OutBus   : last read data (held)
//   MEM_WAIT_RESPONDER_Busy_Out      : high outside IDLE
//   MEM_WAIT_RESPONDER_Error_Out     : sticky access-error flag
module mem_wait_responder
    import mem_wait_responder_pkg::*;
#(
    parameter int DATAWIDTH_BUS   = BUS_WIDTH,
    parameter int ADDR_WORDS_LOG2 = 6,
    parameter int WAIT_STATES     = 2
) (
    input  logic                     MEM_WAIT_RESPONDER_CLOCK_50,
    input  logic                     MEM_WAIT_RESPONDER_ResetInLow_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_WAIT_RESPONDER_A_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MEM_WAIT_RESPONDER_B_InBus,
    input  logic                     MEM_WAIT_RESPONDER_RD_In,
    input  logic                     MEM_WAIT_RESPONDER_WRMain_In,
    output logic                     MEM_WAIT_RESPONDER_ACK_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_WAIT_RESPONDER_Data_OutBus,
    output logic                     MEM_WAIT_RESPONDER_Busy_Out,
    output logic                     MEM_WAIT_RESPONDER_Error_Out
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_e                   state_q, state_d;
    logic [WAIT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
    logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH_BUS-1:0] data_q, data_d;
    logic                     wr_q, wr_d;
    logic                     both_q, both_d;
    logic                     ack_q, ack_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;

    logic                     req;
    logic                     idle;
    logic [DATAWIDTH_BUS-1:0] cur_addr;
    logic [DATAWIDTH_BUS-1:0] cur_wdata;
    logic                     cur_wr;
    logic                     cur_both;
    logic                     bad_addr;
    logic                     enter_ack;
    logic                     ram_we;
    logic [DATAWIDTH_BUS-1:0] ram_rdata;

    assign req  = MEM_WAIT_RESPONDER_RD_In | MEM_WAIT_RESPONDER_WRMain_In;
    assign idle = (state_q == ST_IDLE);

    // With zero wait states the access completes on the sampling edge, so the
    // decode must look at the live bus in IDLE and at the captured copy after.
    assign cur_addr  = idle ? MEM_WAIT_RESPONDER_A_InBus : addr_q;
    assign cur_wdata = idle ? MEM_WAIT_RESPONDER_B_InBus : wdata_q;
    assign cur_wr    = idle ? (MEM_WAIT_RESPONDER_WRMain_In & ~MEM_WAIT_RESPONDER_RD_In) : wr_q;
    assign cur_both  = idle ? (MEM_WAIT_RESPONDER_WRMain_In & MEM_WAIT_RESPONDER_RD_In) : both_q;

    assign bad_addr = (|cur_addr[1:0]) | (|cur_addr[DATAWIDTH_BUS-1:ADDR_WORDS_LOG2+2]);

    mem_wait_ram #(
        .DATA_W (DATAWIDTH_BUS),
        .IDX_W  (ADDR_WORDS_LOG2)
    ) u_ram (
        .clk_i   (MEM_WAIT_RESPONDER_CLOCK_50),
        .we_i    (ram_we),
        .idx_i   (cur_addr[ADDR_WORDS_LOG2+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        both_d    = both_q;
        data_d    = data_q;
        err_d     = err_q;
        enter_ack = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = MEM_WAIT_RESPONDER_A_InBus;
                    wdata_d = MEM_WAIT_RESPONDER_B_InBus;
                    wr_d    = MEM_WAIT_RESPONDER_WRMain_In & ~MEM_WAIT_RESPONDER_RD_In;
                    both_d  = MEM_WAIT_RESPONDER_WRMain_In & MEM_WAIT_RESPONDER_RD_In;
                    if (NO_WAIT) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            default: begin
                // RELEASE: a request still held from the last access must drop
                // before we return to IDLE, so it is never serviced twice.
                if (!req) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Bad addresses and RD+WRMain collisions still complete, but suppressed.
        ram_we = enter_ack & cur_wr & ~bad_addr;
        if (enter_ack && !cur_wr) begin
            data_d = bad_addr ? '0 : ram_rdata;
        end
        if (enter_ack && (bad_addr || cur_both)) begin
            err_d = 1'b1;
        end

        ack_d  = enter_ack;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge MEM_WAIT_RESPONDER_CLOCK_50 or negedge MEM_WAIT_RESPONDER_ResetInLow_In) begin
        if (!MEM_WAIT_RESPONDER_ResetInLow_In) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign MEM_WAIT_RESPONDER_ACK_Out     = ack_q;
    assign MEM_WAIT_RESPONDER_Data_OutBus = data_q;
    assign MEM_WAIT_RESPONDER_Busy_Out    = busy_q;
    assign MEM_WAIT_RESPONDER_Error_Out   = err_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// tb/tb_mem_wait_responder.sv - directed self-checking bench for mem_wait_responder
module tb_mem_wait_responder;

    logic        clk = 1'b0;
    logic        rst2_n, rst3_n;
    logic [31:0] a, b;
    logic        rd, wr;

    logic        ack2, busy2, err2;
    logic [31:0] data2;
    logic        ack3, busy3, err3;
    logic [31:0] data3;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_wait_responder #(.DATAWIDTH_BUS(32), .ADDR_WORDS_LOG2(6), .WAIT_STATES(2)) u_dut2 (
        .MEM_WAIT_RESPONDER_CLOCK_50      (clk),
        .MEM_WAIT_RESPONDER_ResetInLow_In (rst2_n),
        .MEM_WAIT_RESPONDER_A_InBus       (a),
        .MEM_WAIT_RESPONDER_B_InBus       (b),
        .MEM_WAIT_RESPONDER_RD_In         (rd),
        .MEM_WAIT_RESPONDER_WRMain_In     (wr),
        .MEM_WAIT_RESPONDER_ACK_Out       (ack2),
        .MEM_WAIT_RESPONDER_Data_OutBus   (data2),
        .MEM_WAIT_RESPONDER_Busy_Out      (busy2),
        .MEM_WAIT_RESPONDER_Error_Out     (err2)
    );

    mem_wait_responder #(.DATAWIDTH_BUS(32), .ADDR_WORDS_LOG2(6), .WAIT_STATES(3)) u_dut3 (
        .MEM_WAIT_RESPONDER_CLOCK_50      (clk),
        .MEM_WAIT_RESPONDER_ResetInLow_In (rst3_n),
        .MEM_WAIT_RESPONDER_A_InBus       (a),
        .MEM_WAIT_RESPONDER_B_InBus       (b),
        .MEM_WAIT_RESPONDER_RD_In         (rd),
        .MEM_WAIT_RESPONDER_WRMain_In     (wr),
        .MEM_WAIT_RESPONDER_ACK_Out       (ack3),
        .MEM_WAIT_RESPONDER_Data_OutBus   (data3),
        .MEM_WAIT_RESPONDER_Busy_Out      (busy3),
        .MEM_WAIT_RESPONDER_Error_Out     (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic ack_of(input int sel);
        return (sel == 3) ? ack3 : ack2;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 3) ? busy3 : busy2;
    endfunction

    function automatic logic [31:0] data_of(input int sel);
        return (sel == 3) ? data3 : data2;
    endfunction

    // Both DUTs see the same requests; 'sel' picks whose ACK ends the access.
    // Called #1 after a rising edge; returns the same way with both DUTs in IDLE.
    task automatic access(input int sel, input logic do_rd, input logic do_wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        rd = do_rd; wr = do_wr; a = addr; b = wdata;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack_of(sel)) break;
            check("busy_during_wait", busy_of(sel), 1'b1);
        end
        check("ack_seen", ack_of(sel), 1'b1);
        rdata = data_of(sel);
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", ack_of(sel), 1'b0);
        check("busy_in_release", busy_of(sel), 1'b1);
        check("data_hold", data_of(sel), rdata);
        repeat (2) @(posedge clk);
        #1;
        check("busy_back_idle", busy_of(sel), 1'b0);
    endtask

    task automatic pulse_reset();
        rst2_n = 1'b0; rst3_n = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1; rst3_n = 1'b1;
    endtask

    logic [31:0] rdata;
    int          lat;
    int          acks;

    initial begin
        rst2_n = 1'b0; rst3_n = 1'b0;
        a = '0; b = '0; rd = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack2, 1'b0);
        check("rst_data", data2, 32'h0);
        check("rst_busy", busy2, 1'b0);
        check("rst_err", err2, 1'b0);
        rst2_n = 1'b1; rst3_n = 1'b1;
        @(posedge clk); #1;

        // Write then read, WAIT_STATES=2.
        access(2, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, rdata, lat);
        check("wr_latency", lat, 3);
        check("wr_data_untouched", rdata, 32'h0);
        check("wr_no_err", err2, 1'b0);
        access(2, 1'b1, 1'b0, 32'h08, 32'h0, rdata, lat);
        check("rd_latency", lat, 3);
        check("rd_data", rdata, 32'hDEADBEEF);
        check("rd_data_after", data2, 32'hDEADBEEF);

        // Preload words used later.
        access(2, 1'b0, 1'b1, 32'h00, 32'hCAFEF00D, rdata, lat);
        access(2, 1'b0, 1'b1, 32'h10, 32'hAAAA0000, rdata, lat);
        access(2, 1'b0, 1'b1, 32'h0C, 32'h11111111, rdata, lat);
        access(2, 1'b0, 1'b1, 32'h04, 32'h00000404, rdata, lat);
        check("wr_keeps_data", data2, 32'hDEADBEEF);

        // WAIT_STATES=3 latency.
        access(3, 1'b1, 1'b0, 32'h10, 32'h0, rdata, lat);
        check("ws3_latency", lat, 4);
        check("ws3_data", rdata, 32'hAAAA0000);

        // Held request: one ACK only, stays in RELEASE until RD drops.
        rd = 1'b1; a = 32'h04;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack2) acks++;
        end
        check("held_one_ack", acks, 1);
        check("held_busy", busy2, 1'b1);
        check("held_data", data2, 32'h00000404);
        rd = 1'b0;
        @(posedge clk); #1;
        check("held_to_idle", busy2, 1'b0);

        // Misaligned read, then a legal read keeps Error.
        access(2, 1'b1, 1'b0, 32'h05, 32'h0, rdata, lat);
        check("mis_latency", lat, 3);
        check("mis_data", rdata, 32'h0);
        check("mis_err", err2, 1'b1);
        access(2, 1'b1, 1'b0, 32'h08, 32'h0, rdata, lat);
        check("legal_after_mis", rdata, 32'hDEADBEEF);
        check("err_sticky", err2, 1'b1);

        // Out-of-range write must not alias onto word 0.
        pulse_reset();
        check("err_cleared", err2, 1'b0);
        access(2, 1'b0, 1'b1, 32'h100, 32'h12345678, rdata, lat);
        check("oor_err", err2, 1'b1);
        access(2, 1'b1, 1'b0, 32'h00, 32'h0, rdata, lat);
        check("oor_no_alias", rdata, 32'hCAFEF00D);

        // Simultaneous RD and WRMain.
        pulse_reset();
        access(2, 1'b1, 1'b1, 32'h10, 32'h55555555, rdata, lat);
        check("both_read", rdata, 32'hAAAA0000);
        check("both_err", err2, 1'b1);
        access(2, 1'b1, 1'b0, 32'h10, 32'h0, rdata, lat);
        check("both_word_kept", rdata, 32'hAAAA0000);

        // Reset in the 2nd wait cycle of a WAIT_STATES=3 write.
        wr = 1'b1; a = 32'h0C; b = 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst3_n = 1'b0;
        #1;
        check("rstw_ack", ack3, 1'b0);
        check("rstw_busy", busy3, 1'b0);
        check("rstw_data", data3, 32'h0);
        check("rstw_err", err3, 1'b0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack3) acks++;
        end
        wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        @(posedge clk); #1;
        check("rstw_no_ack", acks, 0);
        access(3, 1'b1, 1'b0, 32'h0C, 32'h0, rdata, lat);
        check("rstw_word_kept", rdata, 32'h11111111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
